// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a 24-hour clock: mode/inc buttons edit hour and minute,
// with auto-repeat, blink, idle timeout and a one-cycle load strobe back to the counter.
`timescale 1ns/1ps
module clock_set_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       rep_tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       run_tick,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [4:0] disp_hour,
  output logic [5:0] disp_min,
  output logic [1:0] state,
  output logic       blink
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StBad     = 2'd3
  } state_e;

  state_e     r_state;
  logic       r_mode_prev;
  logic       r_inc_prev;
  logic       r_load;
  logic       r_blink;
  logic [4:0] r_edit_hour;
  logic [5:0] r_edit_min;
  logic [1:0] r_hold;
  logic [4:0] r_idle;

  logic w_mode_edge;
  logic w_inc_edge;
  logic w_in_set;
  logic w_rep_fire;
  logic w_bump;
  logic w_timeout;

  assign w_mode_edge = mode_btn & ~r_mode_prev;
  assign w_inc_edge  = inc_btn & ~r_inc_prev;
  assign w_in_set    = (r_state == StSetHour) || (r_state == StSetMin);
  // Repeat fires only once the hold counter has absorbed the first two strobes.
  assign w_rep_fire  = inc_btn & rep_tick & (r_hold == 2'd2);
  assign w_bump      = w_inc_edge | w_rep_fire;
  assign w_timeout   = (r_idle == 5'd30);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StRun;
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
      r_load      <= 1'b0;
      r_blink     <= 1'b0;
      r_edit_hour <= 5'd0;
      r_edit_min  <= 6'd0;
      r_hold      <= 2'd0;
      r_idle      <= 5'd0;
    end else begin
      r_mode_prev <= mode_btn;
      r_inc_prev  <= inc_btn;
      r_load      <= 1'b0;

      if (!inc_btn || !w_in_set) begin
        r_hold <= 2'd0;
      end else if (rep_tick && (r_hold != 2'd2)) begin
        r_hold <= r_hold + 2'd1;
      end

      case (r_state)
        StRun: begin
          r_idle  <= 5'd0;
          r_blink <= 1'b0;
          if (w_mode_edge) begin
            r_state     <= StSetHour;
            r_edit_hour <= cur_hour;
            r_edit_min  <= cur_min;
            r_blink     <= 1'b1;
          end
        end
        StSetHour, StSetMin: begin
          if (w_mode_edge) begin
            r_idle <= 5'd0;
            if (r_state == StSetHour) begin
              r_state <= StSetMin;
              r_blink <= 1'b1;
            end else begin
              r_state <= StRun;
              r_blink <= 1'b0;
              r_load  <= 1'b1;
            end
          end else if (w_timeout) begin
            // Abandon the edit silently; the counter keeps its own time.
            r_state <= StRun;
            r_blink <= 1'b0;
            r_idle  <= 5'd0;
          end else begin
            if (rep_tick) begin
              r_blink <= ~r_blink;
            end
            if (w_bump) begin
              r_idle <= 5'd0;
              if (r_state == StSetHour) begin
                r_edit_hour <= (r_edit_hour == 5'd23) ? 5'd0 : r_edit_hour + 5'd1;
              end else begin
                r_edit_min <= (r_edit_min == 6'd59) ? 6'd0 : r_edit_min + 6'd1;
              end
            end else if (tick) begin
              r_idle <= r_idle + 5'd1;
            end
          end
        end
        default: begin
          r_state <= StRun;
          r_blink <= 1'b0;
          r_idle  <= 5'd0;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign load      = r_load;
  assign load_hour = r_edit_hour;
  assign load_min  = r_edit_min;
  assign blink     = r_blink;
  assign run_tick  = tick & (r_state == StRun) & ~r_load;
  assign disp_hour = (r_state == StRun) ? cur_hour : r_edit_hour;
  assign disp_min  = (r_state == StRun) ? cur_min : r_edit_min;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and randomized checks of clock_set_ctrl; random edits are predicted with
// modular arithmetic over button-press counts rather than a cycle model.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick, rep_tick, mode_btn, inc_btn;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic       run_tick, load, blink;
  logic [4:0] load_hour, disp_hour;
  logic [5:0] load_min, disp_min;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;
  int load_cnt = 0;
  int rt_cnt = 0;

  always #5 clk = ~clk;

  clock_set_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .rep_tick  (rep_tick),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .run_tick  (run_tick),
    .load      (load),
    .load_hour (load_hour),
    .load_min  (load_min),
    .disp_hour (disp_hour),
    .disp_min  (disp_min),
    .state     (state),
    .blink     (blink)
  );

  always @(negedge clk) begin
    if (load === 1'b1) load_cnt++;
    if (run_tick === 1'b1) rt_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; step(1);
    mode_btn = 1'b0; step(1);
  endtask

  task automatic press_inc();
    inc_btn = 1'b1; step(1);
    inc_btn = 1'b0; step(1);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(1);
    tick = 1'b0; step(1);
  endtask

  task automatic pulse_rep();
    rep_tick = 1'b1; step(1);
    rep_tick = 1'b0; step(1);
  endtask

  initial begin
    int lc0, rc0, ch, cm, nh, nm, nr, exp_h, exp_m;

    reset_n = 1'b0; tick = 1'b0; rep_tick = 1'b0;
    mode_btn = 1'b1; inc_btn = 1'b1;
    cur_hour = 5'd13; cur_min = 6'd45;
    step(3);
    chk("rst_state", state, 0);
    chk("rst_load", load, 0);
    chk("rst_blink", blink, 0);
    chk("rst_edit_h", load_hour, 0);
    chk("rst_edit_m", load_min, 0);

    // Buttons held through reset release must not create edges.
    reset_n = 1'b1;
    step(3);
    chk("held_no_edge", state, 0);
    mode_btn = 1'b0; inc_btn = 1'b0;
    step(2);

    tick = 1'b1; #1;
    chk("run_tick_run", run_tick, 1);
    tick = 1'b0;
    step(1);

    press_inc();
    chk("inc_ignored_run", disp_hour, 13);

    press_mode();
    chk("s1_state", state, 1);
    chk("s1_disp_h", disp_hour, 13);
    chk("s1_disp_m", disp_min, 45);
    chk("s1_blink", blink, 1);
    repeat (3) press_inc();
    chk("s1_hour16", disp_hour, 16);
    press_mode();
    chk("s1_setmin", state, 2);
    lc0 = load_cnt;
    mode_btn = 1'b1; step(1);
    chk("s1_run", state, 0);
    chk("s1_load", load, 1);
    chk("s1_load_h", load_hour, 16);
    chk("s1_load_m", load_min, 45);
    tick = 1'b1; #1;
    chk("s1_rt_load", run_tick, 0);
    tick = 1'b0;
    mode_btn = 1'b0; step(1);
    chk("s1_load_off", load, 0);
    chk("s1_load_once", load_cnt - lc0, 1);

    cur_hour = 5'd23; cur_min = 6'd59;
    press_mode();
    press_inc();
    chk("wrap_hour", disp_hour, 0);
    press_mode();
    press_inc();
    chk("wrap_min", disp_min, 0);
    press_mode();
    chk("wrap_load_h", load_hour, 0);
    chk("wrap_load_m", load_min, 0);

    cur_hour = 5'd5; cur_min = 6'd10;
    press_mode(); press_mode();
    inc_btn = 1'b1; step(1);
    chk("rep_edge", disp_min, 11);
    for (int i = 0; i < 6; i++) begin
      pulse_rep();
      if (i == 1) chk("rep_hold2", disp_min, 11);
    end
    chk("rep_15", disp_min, 15);
    chk("rep_blink", blink, 1);
    inc_btn = 1'b0; step(1);
    pulse_rep();
    chk("rep_released", disp_min, 15);
    press_mode();
    chk("rep_load_m", load_min, 15);

    cur_hour = 5'd7; cur_min = 6'd20;
    lc0 = load_cnt; rc0 = rt_cnt;
    press_mode();
    repeat (29) pulse_tick();
    chk("to_29", state, 1);
    pulse_tick();
    step(2);
    chk("to_state", state, 0);
    chk("to_no_load", load_cnt - lc0, 0);
    chk("to_no_rt", rt_cnt - rc0, 0);
    chk("to_disp_h", disp_hour, 7);

    cur_hour = 5'd9; cur_min = 6'd30;
    press_mode();
    mode_btn = 1'b1; inc_btn = 1'b1; step(1);
    chk("both_state", state, 2);
    chk("both_hour", load_hour, 9);
    mode_btn = 1'b0; inc_btn = 1'b0; step(1);
    press_mode();

    lc0 = load_cnt;
    press_mode(); press_mode(); press_inc();
    chk("rst_mid_pre", state, 2);
    #2 reset_n = 1'b0; #1;
    chk("rst_mid_state", state, 0);
    chk("rst_mid_load", load, 0);
    step(2);
    reset_n = 1'b1;
    step(2);
    chk("rst_mid_noload", load_cnt - lc0, 0);

    for (int it = 0; it < 20; it++) begin
      ch = $urandom_range(0, 23);
      cm = $urandom_range(0, 59);
      nh = $urandom_range(0, 30);
      nm = $urandom_range(0, 70);
      nr = $urandom_range(0, 5);
      cur_hour = 5'(ch); cur_min = 6'(cm);
      rc0 = rt_cnt;
      press_mode();
      for (int k = 0; k < nh; k++) begin
        press_inc();
        if ($urandom_range(0, 3) == 0) pulse_tick();
      end
      press_mode();
      for (int k = 0; k < nm; k++) begin
        press_inc();
        if ($urandom_range(0, 3) == 0) pulse_tick();
      end
      inc_btn = 1'b1; step(1);
      repeat (nr) pulse_rep();
      inc_btn = 1'b0; step(1);
      exp_h = (ch + nh) % 24;
      exp_m = (cm + nm + 1 + ((nr > 2) ? nr - 2 : 0)) % 60;
      mode_btn = 1'b1; step(1);
      chk("rnd_load", load, 1);
      chk("rnd_load_h", load_hour, exp_h);
      chk("rnd_load_m", load_min, exp_m);
      chk("rnd_no_rt", rt_cnt - rc0, 0);
      mode_btn = 1'b0; step(2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  1 Hz one-cycle strobe
- rep_tick  in  1  4 Hz one-cycle strobe for auto-repeat and blink
- mode_btn  in  1  debounced, synchronized level; 1 = pressed
- inc_btn  in  1  debounced, synchronized level; 1 = pressed
- cur_hour  in  5  running hour from the time counter, 0..23
- cur_min  in  6  running minute from the time counter, 0..59
- run_tick  out  1  gated 1 Hz strobe to the time counter
- load  out  1  one-cycle strobe: counter loads load_hour/load_min and clears sec
- load_hour  out  5  hour value to load
- load_min  out  6  minute value to load
- disp_hour  out  5  hour to display
- disp_min  out  6  minute to display
- state  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
- blink  out  1  flash enable for the field being edited

Function
REQ-002 Edge detect: mode_edge and inc_edge SHALL each be 1 when the button level is 1 now and was 0 on the previous cycle.
REQ-003 State transitions on mode_edge SHALL be: RUN->SET_HOUR, SET_HOUR->SET_MIN, SET_MIN->RUN. State encoding 3 SHALL be unreachable; if entered, the next state SHALL be RUN.
REQ-004 On RUN->SET_HOUR, edit_hour SHALL capture cur_hour and edit_min SHALL capture cur_min in the same clock edge.
REQ-005 On SET_MIN->RUN via mode_edge:
- load=1 for exactly the first RUN cycle;
- load_hour=edit_hour and load_min=edit_min during that cycle.
REQ-006 load_hour/load_min SHALL continuously present edit_hour/edit_min.
REQ-007 load SHALL be 0 in all other cycles.
REQ-008 run_tick SHALL equal tick only when state=RUN and load=0; otherwise run_tick SHALL be 0, so no seconds are lost or counted during editing.
REQ-009 inc_edge in SET_HOUR SHALL increment edit_hour, wrapping 23->0.
REQ-010 inc_edge in SET_MIN SHALL increment edit_min, wrapping 59->0.
REQ-011 inc_edge in RUN SHALL be ignored.
REQ-012 Auto-repeat: while inc_btn stays 1 in a SET state, the first 2 rep_tick strobes after the press SHALL only advance a saturating 2-bit hold counter; each later rep_tick SHALL increment the active field once. The hold counter SHALL clear when inc_btn=0.
REQ-013 Simultaneous mode_edge and inc_edge/repeat: mode SHALL take priority, and that cycle's increment SHALL be dropped.
REQ-014 Timeout:
- a 5-bit idle counter SHALL count tick strobes in SET states;
- the counter SHALL clear on any mode_edge, inc_edge or repeat increment, and on entry to RUN;
- on reaching 30, state SHALL go to RUN with no load pulse (edit aborted).
REQ-015 Timeout and mode_edge in the same cycle: mode_edge SHALL win.
REQ-016 disp_hour/disp_min SHALL be cur_hour/cur_min in RUN and edit_hour/edit_min in SET states.
REQ-017 blink SHALL be 0 in RUN, SHALL be set to 1 on entry to any SET state, and SHALL toggle on each rep_tick while in a SET state.
REQ-018 All outputs SHALL be registered, except run_tick, disp_hour and disp_min, which may be combinational from registered state.

Reset
REQ-019 While reset_n=0, the block SHALL hold: state=RUN, load=0, blink=0, edit_hour=0, edit_min=0, hold counter=0, idle counter=0.
REQ-020 Button-history registers SHALL reset to 1, so a button held through reset release produces no edge.
REQ-021 Assertion of reset_n mid-edit SHALL discard edits without a load pulse.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- In RUN with cur=13:45: mode press -> state=1, disp=13:45, blink=1. Three inc presses -> disp_hour=16. Mode press -> state=2. Mode press -> state=0, one-cycle load, load_hour=16, load_min=45.
- In SET_HOUR with edit_hour=23: one inc press -> edit_hour=0. In SET_MIN with edit_min=59: one inc press -> edit_min=0.
- inc held for 6 rep_tick strobes in SET_MIN from 10 -> edit_min=15 (1 edge increment plus 4 repeats).
- Enter SET_HOUR, no buttons for 30 ticks -> state=0, load never 1, run_tick=0 throughout the edit.
- mode_edge and inc_edge in the same cycle in SET_HOUR -> state=2, edit_hour unchanged.
- Both buttons held while reset_n deasserts -> no transition; reset_n asserted in SET_MIN -> state=0, load=0.
